// File: rtl/cs_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module   : cs_stream_feeder
// Purpose  : Buffers host bytes and streams them gap-free into the CS window
//            engine, returning CS results once a full window is in place.
// Config   : STATUS_CNT_EN adds sample_cnt / frame_cnt status ports.
// Revision : 1.0 - initial release
// ============================================================================
module cs_stream_feeder #(
    parameter int FIFO_DEPTH  = 16,
    parameter int PRIME_LEVEL = 9,
    parameter int WIN         = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        start,
    output logic [7:0]  x_out,
    output logic        cs_clr,
    input  logic [9:0]  y_in,
    output logic [9:0]  res_data,
    output logic        res_valid,
    output logic        busy,
    output logic        underrun
`ifdef STATUS_CNT_EN
    ,
    output logic [15:0] sample_cnt,
    output logic [15:0] frame_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(WIN + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_PRIME  = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [CW-1:0] count;
    logic [8:0]    head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          flush;
    logic          enter_err;

    logic [WW-1:0] wcnt;
    logic [WW-1:0] wcnt_inc;
    logic          win_full;
    logic          v0;
    logic          v1;
    logic          drain_cnt;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr[AW-1:0]];
    assign busy     = (state != S_IDLE);

    assign wcnt_inc = (wcnt == WW'(WIN)) ? wcnt : wcnt + WW'(1);
    assign win_full = pop && (wcnt_inc == WW'(WIN));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
        end
    end

    always_comb begin
        state_nx  = state;
        pop       = 1'b0;
        flush     = 1'b0;
        enter_err = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_CLEAR;
            end
            S_CLEAR: begin
                state_nx = S_PRIME;
            end
            S_PRIME: begin
                if (count >= CW'(PRIME_LEVEL)) state_nx = S_STREAM;
            end
            S_STREAM: begin
                if (empty) begin
                    enter_err = 1'b1;
                    state_nx  = S_ERR;
                end else begin
                    pop = 1'b1;
                    if (head[8]) state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Hold until the result pipe has emptied so no result outlives busy.
                if (drain_cnt && !(v0 || v1 || res_valid)) state_nx = S_IDLE;
            end
            S_ERR: begin
                if (start) begin
                    flush    = 1'b1;
                    state_nx = S_CLEAR;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            x_out     <= 8'd0;
            cs_clr    <= 1'b0;
            res_data  <= 10'd0;
            res_valid <= 1'b0;
            v0        <= 1'b0;
            v1        <= 1'b0;
            underrun  <= 1'b0;
            wcnt      <= '0;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_nx;
            cs_clr    <= (state_nx == S_CLEAR);
            x_out     <= pop ? head[7:0] : 8'd0;
            drain_cnt <= (state == S_DRAIN);

            if (push) wr_ptr <= wr_ptr + 1'b1;
            // A push coinciding with the flush survives it.
            if (flush)    rd_ptr <= wr_ptr;
            else if (pop) rd_ptr <= rd_ptr + 1'b1;

            if (state == S_CLEAR) wcnt <= '0;
            else if (pop)         wcnt <= wcnt_inc;

            if (enter_err) begin
                v0        <= 1'b0;
                v1        <= 1'b0;
                res_valid <= 1'b0;
            end else begin
                v0        <= win_full;
                v1        <= v0;
                res_valid <= v1;
                if (v1) res_data <= y_in;
            end

            if (enter_err)  underrun <= 1'b1;
            else if (flush) underrun <= 1'b0;
        end
    end

`ifdef STATUS_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_cnt <= 16'd0;
            frame_cnt  <= 16'd0;
        end else begin
            if (state_nx == S_CLEAR && state != S_CLEAR) sample_cnt <= 16'd0;
            else if (pop)                                sample_cnt <= sample_cnt + 16'd1;
            if (state == S_DRAIN && state_nx == S_IDLE)  frame_cnt  <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cs_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cs_stream_feeder
// Purpose  : Self-checking bench with a CS window model and frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cs_stream_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic        start;
    logic [7:0]  x_out;
    logic        cs_clr;
    logic [9:0]  y_in;
    logic [9:0]  res_data;
    logic        res_valid;
    logic        busy;
    logic        underrun;
`ifdef STATUS_CNT_EN
    logic [15:0] sample_cnt;
    logic [15:0] frame_cnt;
`endif

    always #5 clk = ~clk;

    cs_stream_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .start     (start),
        .x_out     (x_out),
        .cs_clr    (cs_clr),
        .y_in      (y_in),
        .res_data  (res_data),
        .res_valid (res_valid),
        .busy      (busy),
        .underrun  (underrun)
`ifdef STATUS_CNT_EN
        ,
        .sample_cnt(sample_cnt),
        .frame_cnt (frame_cnt)
`endif
    );

    // CS engine stand-in: 9-deep shift window, Y = window sum / 4.
    logic [7:0]  cs_win [9];
    logic [11:0] cs_sum;
    always @(posedge clk or posedge reset) begin
        if (reset || cs_clr) begin
            for (int i = 0; i < 9; i++) cs_win[i] <= 8'd0;
        end else begin
            cs_win[0] <= x_out;
            for (int i = 1; i < 9; i++) cs_win[i] <= cs_win[i-1];
        end
    end
    always_comb begin
        cs_sum = 12'd0;
        for (int i = 0; i < 9; i++) cs_sum = cs_sum + 12'(cs_win[i]);
    end
    assign y_in = cs_sum[11:2];

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] fb [$];
    logic [8:0] feed_q [$];
    bit         gaps = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] exp_y(input int n);
        int s;
        s = 0;
        for (int i = n - 8; i <= n; i++) s += int'(fb[i]);
        return 10'(s >> 2);
    endfunction

    // Host driver: presents queue head, retires it when accepted.
    initial begin
        bit acc;
        in_valid = 1'b0;
        in_data  = 8'd0;
        in_last  = 1'b0;
        forever begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc && !reset && feed_q.size() > 0) void'(feed_q.pop_front());
            #1;
            if (feed_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                {in_last, in_data} = feed_q[0];
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_data  = 8'd0;
            end
        end
    end

    task automatic wait_empty(input string tag);
        int t;
        t = 0;
        while (feed_q.size() > 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_feed_drain"}, feed_q.size(), 0);
        feed_q.delete();
    endtask

    task automatic do_reset();
        feed_q.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // One frame: prefill, start, then cycle-by-cycle compare against the model.
    task automatic run_frame(input int L, input bit has_last, input bit rnd, input int base,
                             input int exp_nres, input bit exp_ur, input string tag);
        int  nres;
        int  n;
        bit  exp_rv;
        logic [7:0] ex_x;
        fb.delete();
        for (int i = 0; i < L; i++) fb.push_back(rnd ? 8'($urandom) : 8'(base + i));
        gaps = rnd;
        for (int i = 0; i < L && i < 16; i++) feed_q.push_back({has_last && i == L - 1, fb[i]});
        wait_empty(tag);
        gaps = 1'b0;
        if (L > 16) begin
            for (int i = 16; i < L; i++) feed_q.push_back({has_last && i == L - 1, fb[i]});
            repeat (3) begin
                @(negedge clk);
                chk({tag, "_in_ready_full"}, in_ready, 0);
            end
            chk({tag, "_held_byte_not_taken"}, feed_q.size(), L - 16);
        end
        @(negedge clk);
        start = 1'b1;
        nres = 0;
        for (int k = 1; k <= L + 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            ex_x = (k >= 4 && k <= L + 3) ? fb[k-4] : 8'd0;
            chk($sformatf("%s_x_out_k%0d", tag, k), x_out, ex_x);
            chk($sformatf("%s_cs_clr_k%0d", tag, k), cs_clr, k == 1);
            n = k - 6;
            exp_rv = (n >= 8) && (n <= L - 1) && (has_last || n <= L - 3);
            chk($sformatf("%s_res_valid_k%0d", tag, k), res_valid, exp_rv);
            if (exp_rv && res_valid) chk($sformatf("%s_res_data_n%0d", tag, n), res_data, exp_y(n));
            if (res_valid) nres++;
            if (has_last) begin
                if (k <= L + 5) chk($sformatf("%s_busy_k%0d", tag, k), busy, 1);
                if (k >= L + 8) chk($sformatf("%s_idle_k%0d", tag, k), busy, 0);
            end else begin
                chk($sformatf("%s_underrun_k%0d", tag, k), underrun, k >= L + 4);
                chk($sformatf("%s_busy_err_k%0d", tag, k), busy, 1);
            end
        end
        chk({tag, "_result_count"}, nres, exp_nres);
        chk({tag, "_underrun_end"}, underrun, exp_ur);
        if (has_last) chk({tag, "_res_data_hold"}, res_data, exp_y(L - 1));
    endtask

    typedef struct {
        int len;
        bit has_last;
        int base;
        int exp_nres;
        bit exp_ur;
    } vec_t;

    vec_t       tbl [6];
    logic [7:0] got [$];

    initial begin
        int nres;
        int L;
        bit hl;
        tbl[0] = '{9,  1'b1, 10,  1,  1'b0};
        tbl[1] = '{20, 1'b1, 30,  12, 1'b0};
        tbl[2] = '{16, 1'b1, 60,  8,  1'b0};
        tbl[3] = '{10, 1'b1, 120, 2,  1'b0};
        tbl[4] = '{12, 1'b0, 80,  2,  1'b1};
        tbl[5] = '{9,  1'b0, 90,  0,  1'b1};

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_x_out", x_out, 0);
        chk("rst_cs_clr", cs_clr, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef STATUS_CNT_EN
        chk("rst_sample_cnt", sample_cnt, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
`endif
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i].len, tbl[i].has_last, 1'b0, tbl[i].base,
                      tbl[i].exp_nres, tbl[i].exp_ur, $sformatf("vec%0d", i));
            if (tbl[i].exp_ur && i != 5) do_reset();
        end

        // Recovery from ERR: bytes queued before start must be flushed.
        for (int i = 0; i < 3; i++) feed_q.push_back({1'b0, 8'(200 + i)});
        wait_empty("err_junk");
        @(negedge clk);
        chk("err_busy", busy, 1);
        chk("err_underrun", underrun, 1);
        chk("err_x_out", x_out, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("flush_underrun_clr", underrun, 0);
        chk("flush_cs_clr", cs_clr, 1);
        fb.delete();
        for (int i = 0; i < 9; i++) fb.push_back(8'(50 + i));
        for (int i = 0; i < 9; i++) feed_q.push_back({i == 8, fb[i]});
        got.delete();
        nres = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (x_out != 8'd0) got.push_back(x_out);
            if (res_valid) begin
                nres++;
                chk("flush_res_data", res_data, exp_y(8));
            end
        end
        chk("flush_pop_count", got.size(), 9);
        for (int i = 0; i < got.size() && i < 9; i++) chk($sformatf("flush_x%0d", i), got[i], fb[i]);
        chk("flush_result_count", nres, 1);
        chk("flush_idle", busy, 0);

        // Reset during STREAM after 5 pops.
        fb.delete();
        for (int i = 0; i < 12; i++) fb.push_back(8'(100 + i));
        for (int i = 0; i < 12; i++) feed_q.push_back({i == 11, fb[i]});
        wait_empty("rst_mid");
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("rst_mid_x_before", x_out, fb[4]);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_x_out", x_out, 0);
        chk("rst_mid_res_valid", res_valid, 0);
        chk("rst_mid_res_data", res_data, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_cs_clr", cs_clr, 0);
        chk("rst_mid_underrun", underrun, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_frame(9, 1'b1, 1'b0, 40, 1, 1'b0, "post_rst");

        // Randomised frames against the frame-level model.
        for (int r = 0; r < 10; r++) begin
            L  = $urandom_range(9, 20);
            hl = ($urandom_range(0, 3) != 0);
            run_frame(L, hl, 1'b1, 0, hl ? L - 8 : (L >= 10 ? L - 10 : 0), !hl,
                      $sformatf("rnd%0d", r));
            if (!hl) do_reset();
        end

`ifdef STATUS_CNT_EN
        do_reset();
        run_frame(10, 1'b1, 1'b1, 0, 2, 1'b0, "stat_a");
        run_frame(10, 1'b1, 1'b1, 0, 2, 1'b0, "stat_b");
        chk("stat_sample_cnt", sample_cnt, 10);
        chk("stat_frame_cnt", frame_cnt, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
